md_ctrl: RTL and testbench
==========================

// Module: md_ctrl
// PURPOSE
//  Multi-cycle multiply/divide controller with the HI/LO register pair, sitting in EX beside the ALU.
//  Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and holds busy for a fixed latency, so the hazard unit
//  can stall later HI/LO users. Writes HI/LO at completion and serves MFHI/MFLO reads combinationally.
// PARAMETERS
//  MUL_LAT  5   cycles busy is high after a MULT/MULTU start cycle (>=1)
//  DIV_LAT  10  cycles busy is high after a DIV/DIVU start cycle (>=1, >= MUL_LAT)
// PORTS
//  clk      in   1   rising-edge clock, single clock domain
//  rst_n    in   1   asynchronous, active-low reset
//  start    in   1   EX holds an md op this cycle; sampled at rising edge
//  mdop     in   3   op code (md_pkg): NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO; valid with start
//  In1      in   32  rs operand (dividend / multiplicand / MTHI-MTLO data)
//  In2      in   32  rt operand (divisor / multiplier)
//  rd_hi    in   1   1: rdata = HI, 0: rdata = LO (MFHI/MFLO)
//  busy     out  1   operation in flight
//  rdata    out  32  selected HI or LO, combinational from the architectural registers
//  hi, lo   out  32  architectural HI/LO, for debug and bench checking
// BEHAVIOUR
//  Reset (async, rst_n=0): HI=0, LO=0, busy=0, cnt=0, pending regs=0; any in-flight op is discarded.
//  States: IDLE (cnt==0, busy=0) and RUN (cnt>0, busy=1). busy is a register, not derived from start.
//  IDLE + start + MULT/MULTU/DIV/DIVU, edge N:
//   - In1/In2 operands latched, result computed into pending P_HI/P_LO.
//   - cnt loads MUL_LAT or DIV_LAT.
//  RUN: cnt decrements each edge. busy stays 1 for exactly LAT cycles (N+1..N+LAT).
//   - At the edge where cnt goes 1->0, HI/LO take P_HI/P_LO.
//   - busy=0 and the new HI/LO are visible in the same cycle. No early visibility.
//  MTHI/MTLO with start in IDLE: HI (or LO) <= In1 at that edge. busy stays 0; latency is one edge.
//  start while busy=1: ignored entirely (no state change). The pipeline guarantees this by stalling.
//   The bench checks that it is ignored.
//  start with mdop=NONE or an undefined code: no effect.
//  Arithmetic:
//   - MULT: {HI,LO} = $signed(In1) * $signed(In2), full 64 bit.
//   - MULTU: unsigned 64-bit product.
//   - DIV: LO = signed quotient truncated toward zero; HI = remainder with the dividend's sign.
//   - DIVU: unsigned quotient and remainder.
//  Boundaries:
//   - Divide by zero (In2==0): the op still runs DIV_LAT cycles with busy; HI/LO are left unchanged.
//   - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (wraps, no trap).
//   - In1/In2 changing after the start edge has no effect on the result.
//   - Reads during RUN return the old HI/LO.
//   - rst_n low mid-RUN: the result is lost, HI/LO are 0, busy drops immediately.
//   - Back-to-back: a new start is accepted in the first cycle busy=0.
// STRUCTURE
//  md_pkg: localparams for mdop encodings (NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6)
//   and the default latencies. The hazard unit imports the same encodings.
//  Sub-module md_calc (combinational): op, a, b -> {p_hi, p_lo, dz}. Holds all signed/unsigned
//   product, quotient and remainder rules plus divide-by-zero detection.
//  md_ctrl keeps the counter, busy, pending registers, HI/LO and the read mux. cnt width = $clog2(DIV_LAT+1).
// TESTING
//  1 MULT: In1=0xFFFFFFFE(-2), In2=3 -> busy 1 for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
//    MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
//  2 DIV: In1=-7 (0xFFFFFFF9), In2=2 -> busy for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//    DIVU: 7/2 -> LO=3, HI=1.
//  3 Start a MULT, then pulse start with MTHI In1=0x1234 mid-RUN -> ignored.
//    After completion HI = the product's high word; next idle MTHI sets HI=0x1234 with busy=0.
//  4 Set HI=0xA, LO=0xB via MTHI/MTLO, then DIV x/0 -> busy for 10 cycles, HI=0xA and LO=0xB unchanged.
//    Then DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
//  5 Start a DIV, assert rst_n=0 asynchronously at RUN cycle 4 -> busy, HI, LO are 0 at once.
//    After release no write occurs and busy stays 0.
//  6 Back-to-back: MULT, then DIVU started the first cycle busy=0 -> second op accepted.
//    rdata with rd_hi=0/1 tracks LO/HI at each update.

Source files
------------

// File: rtl/md_pkg.sv
// md_pkg: multiply/divide op encodings, default latencies and controller state type
package md_pkg;
    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam int MUL_LAT_DEF = 5;
    localparam int DIV_LAT_DEF = 10;
    typedef enum logic {IDLE, RUN} state_e;
    function automatic logic is_mul(input logic [2:0] op);
        return op == OP_MULT || op == OP_MULTU;
    endfunction
    function automatic logic is_div(input logic [2:0] op);
        return op == OP_DIV || op == OP_DIVU;
    endfunction
endpackage

// File: rtl/md_if.sv
// md_if: EX-side request and HI/LO read bus of the multiply/divide controller
interface md_if;
    logic        start;
    logic [2:0]  mdop;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        rd_hi;
    logic        busy;
    logic [31:0] rdata;
    logic [31:0] hi;
    logic [31:0] lo;
    modport master (output start, mdop, in1, in2, rd_hi, input busy, rdata, hi, lo);
    modport slave (input start, mdop, in1, in2, rd_hi, output busy, rdata, hi, lo);
endinterface

// File: rtl/md_calc.sv
// md_calc: combinational product, quotient and remainder for MULT/MULTU/DIV/DIVU with divide-by-zero flag
module md_calc
    import md_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] p_hi_o,
    output logic [31:0] p_lo_o,
    output logic        dz_o
);
    logic        sgn;
    logic [63:0] prod;
    logic [31:0] mag_a, mag_b, q, r, qs, rs;
    always_comb begin
        sgn    = op_i == OP_MULT || op_i == OP_DIV;
        prod   = {{32{sgn & a_i[31]}}, a_i} * {{32{sgn & b_i[31]}}, b_i};
        // Signed divide works on magnitudes; 0x80000000 / -1 wraps back to 0x80000000
        mag_a  = (sgn && a_i[31]) ? -a_i : a_i;
        mag_b  = (sgn && b_i[31]) ? -b_i : b_i;
        dz_o   = b_i == '0;
        q      = dz_o ? '0 : mag_a / mag_b;
        r      = dz_o ? '0 : mag_a % mag_b;
        qs     = (sgn && (a_i[31] ^ b_i[31])) ? -q : q;
        rs     = (sgn && a_i[31]) ? -r : r;
        p_hi_o = is_div(op_i) ? rs : prod[63:32];
        p_lo_o = is_div(op_i) ? qs : prod[31:0];
    end
endmodule

// File: rtl/md_ctrl.sv
// md_ctrl: multi-cycle multiply/divide controller owning HI/LO, busy counter and MFHI/MFLO read mux
module md_ctrl
    import md_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input logic  clk,
    input logic  rst_n,
    md_if.slave  bus
);
    localparam int CW = $clog2(DIV_LAT + 1);
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   phi_q, phi_d, plo_q, plo_d, hi_q, hi_d, lo_q, lo_d;
    logic          pwr_q, pwr_d;
    logic [31:0]   c_hi, c_lo;
    logic          c_dz;
    md_calc u_calc (.op_i(bus.mdop), .a_i(bus.in1), .b_i(bus.in2), .p_hi_o(c_hi), .p_lo_o(c_lo), .dz_o(c_dz));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            phi_q   <= '0;
            plo_q   <= '0;
            pwr_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
            pwr_q   <= pwr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phi_d   = phi_q;
        plo_d   = plo_q;
        pwr_d   = pwr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (state_q == IDLE) begin
            if (bus.start && (is_mul(bus.mdop) || is_div(bus.mdop))) begin
                state_d = RUN;
                cnt_d   = is_div(bus.mdop) ? CW'(DIV_LAT) : CW'(MUL_LAT);
                phi_d   = c_hi;
                plo_d   = c_lo;
                pwr_d   = !(is_div(bus.mdop) && c_dz);
            end
            hi_d = (bus.start && bus.mdop == OP_MTHI) ? bus.in1 : hi_q;
            lo_d = (bus.start && bus.mdop == OP_MTLO) ? bus.in1 : lo_q;
        end else begin
            // Requests arriving while running are dropped; the pipeline stalls them
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                state_d = IDLE;
                hi_d    = pwr_q ? phi_q : hi_q;
                lo_d    = pwr_q ? plo_q : lo_q;
            end
        end
    end
    assign bus.busy  = state_q == RUN;
    assign bus.rdata = bus.rd_hi ? hi_q : lo_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl: directed and random checks of md_ctrl against an arithmetic HI/LO reference model
module tb_md_ctrl;
    import md_pkg::*;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    md_if bus();
    md_ctrl #(.MUL_LAT(5), .DIV_LAT(10)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int lat(input logic [2:0] op);
        return (op == OP_MULT || op == OP_MULTU) ? 5 : (op == OP_DIV || op == OP_DIVU) ? 10 : 0;
    endfunction

    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        case (op)
            OP_MULT:  {m_hi, m_lo} = 64'(sa * sb);
            OP_MULTU: {m_hi, m_lo} = 64'(a) * 64'(b);
            OP_DIV:   if (b != 0) begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
            OP_DIVU:  if (b != 0) begin m_lo = a / b; m_hi = a % b; end
            OP_MTHI:  m_hi = a;
            OP_MTLO:  m_lo = a;
            default:  ;
        endcase
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit inj = 1'b0);
        int          cyc = 0;
        logic [31:0] old_hi = m_hi;
        logic [31:0] old_lo = m_lo;
        bus.start = 1'b1;
        bus.mdop  = op;
        bus.in1   = a;
        bus.in2   = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.in1   = $urandom;
        bus.in2   = $urandom;
        while (bus.busy === 1'b1 && cyc < 40) begin
            chk("run_hi", bus.hi, old_hi);
            chk("run_lo", bus.lo, old_lo);
            bus.start = inj && cyc == 1;
            bus.mdop  = OP_MTHI;
            bus.in1   = 32'h1234;
            cyc++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk("busy_cycles", 32'(cyc), 32'(lat(op)));
        model(op, a, b);
        chk("hi", bus.hi, m_hi);
        chk("lo", bus.lo, m_lo);
        bus.rd_hi = 1'b0;
        #1 chk("rdata_lo", bus.rdata, m_lo);
        bus.rd_hi = 1'b1;
        #1 chk("rdata_hi", bus.rdata, m_hi);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        bus.start = 1'b0;
        bus.mdop  = OP_NONE;
        bus.in1   = '0;
        bus.in2   = '0;
        bus.rd_hi = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        issue(OP_MULT, 32'hFFFFFFFE, 32'd3);
        chk("mult_hi", bus.hi, 32'hFFFFFFFF);
        chk("mult_lo", bus.lo, 32'hFFFFFFFA);
        issue(OP_MULTU, 32'hFFFFFFFE, 32'd3);
        chk("multu_hi", bus.hi, 32'h00000002);
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
        chk("div_lo", bus.lo, 32'hFFFFFFFD);
        chk("div_hi", bus.hi, 32'hFFFFFFFF);
        issue(OP_DIVU, 32'd7, 32'd2);
        chk("divu_lo", bus.lo, 32'd3);
        issue(OP_MULT, 32'h00012345, 32'h00100000, 1'b1);
        chk("inj_hi", bus.hi, 32'h00000012);
        issue(OP_MTHI, 32'h1234, 32'd0);
        chk("mthi_hi", bus.hi, 32'h1234);
        issue(OP_MTHI, 32'hA, 32'd0);
        issue(OP_MTLO, 32'hB, 32'd0);
        issue(OP_DIV, 32'd99, 32'd0);
        chk("dz_hi", bus.hi, 32'hA);
        chk("dz_lo", bus.lo, 32'hB);
        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        chk("ovf_lo", bus.lo, 32'h80000000);
        chk("ovf_hi", bus.hi, 32'd0);
        issue(OP_MTHI, 32'h55, 32'd0);
        issue(OP_NONE, 32'h77, 32'd1);
        issue(3'd7, 32'h77, 32'd1);
        bus.start = 1'b1;
        bus.mdop  = OP_DIV;
        bus.in1   = 32'd100;
        bus.in2   = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_hi", bus.hi, 32'd0);
        chk("arst_lo", bus.lo, 32'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("post_rst_busy", 32'(bus.busy), 32'd0);
        end
        chk("post_rst_hi", bus.hi, 32'd0);
        chk("post_rst_lo", bus.lo, 32'd0);
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            issue(op, a, b, 1'($urandom_range(0, 1)));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
